// File: rtl/fp_itof_pipe_pkg.sv
// Shared FP32 field widths, bias and rounding-mode encoding
// for the fp32_core execute path.
package gpu_parameters;

    typedef enum logic [1:0] {
        RM_RNE = 2'd0,
        RM_RTZ = 2'd1,
        RM_RDN = 2'd2,
        RM_RUP = 2'd3
    } round_mode_e;

    localparam int FP32_EXP_WIDTH  = 8;
    localparam int FP32_MANT_WIDTH = 23;
    localparam int FP32_BIAS       = 127;

    function automatic logic [31:0] fp32_pack(
        input logic                       sign,
        input logic [FP32_EXP_WIDTH-1:0]  exp,
        input logic [FP32_MANT_WIDTH-1:0] mant
    );
        return {sign, exp, mant};
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input
// reports WIDTH.
module fp_lzc #(
    parameter  int WIDTH = 32,
    localparam int CW    = $clog2(WIDTH) + 1
) (
    input  logic [WIDTH-1:0] value,
    output logic [CW-1:0]    count
);

    // Highest set bit wins because later iterations overwrite.
    always_comb begin
        count = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (value[i]) count = CW'(WIDTH - 1 - i);
        end
    end

endmodule

// File: rtl/fp_itof_pipe.sv
// Three-stage integer to FP32 converter with valid/ready
// backpressure and a pass-through issue tag.
module fp_itof_pipe
    import gpu_parameters::*;
#(
    parameter int INT_WIDTH = 32,
    parameter int TAG_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [INT_WIDTH-1:0] in_int,
    input  logic                 in_signed,
    input  round_mode_e          in_rm,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_float,
    output logic                 out_inexact,
    output logic [TAG_WIDTH-1:0] out_tag
);

    localparam int W   = INT_WIDTH;
    localparam int LZW = $clog2(W) + 1;
    localparam int GW  = W + 24;

    if (INT_WIDTH < 8 || INT_WIDTH > 64) begin : g_bad_width
        $fatal(1, "fp_itof_pipe: INT_WIDTH must be 8..64");
    end

    typedef struct packed {
        logic                 sign;
        logic [W-1:0]         mag;
        round_mode_e          rm;
        logic [TAG_WIDTH-1:0] tag;
    } s1_t;

    typedef struct packed {
        logic                 zero;
        logic                 sign;
        logic [W-1:0]         norm;
        logic [7:0]           e;
        round_mode_e          rm;
        logic [TAG_WIDTH-1:0] tag;
    } s2_t;

    typedef struct packed {
        logic [31:0]          f;
        logic                 inexact;
        logic [TAG_WIDTH-1:0] tag;
    } s3_t;

    logic v1, v2, v3, adv, neg;
    s1_t s1, s1_d;
    s2_t s2, s2_d;
    s3_t s3, s3_d;
    logic [LZW-1:0] lz;

    assign adv      = !v3 || out_ready;
    assign in_ready = adv;

    assign neg = in_signed & in_int[W-1];

    always_comb begin
        s1_d      = '0;
        s1_d.sign = neg;
        s1_d.mag  = neg ? -in_int : in_int;
        s1_d.rm   = in_rm;
        s1_d.tag  = in_tag;
    end

    fp_lzc #(.WIDTH(W)) u_lzc (
        .value(s1.mag),
        .count(lz)
    );

    always_comb begin
        s2_d      = '0;
        s2_d.zero = (s1.mag == '0);
        s2_d.sign = s1.sign;
        s2_d.norm = s1.mag << lz;
        s2_d.e    = 8'(W - 1) - 8'(lz);
        s2_d.rm   = s1.rm;
        s2_d.tag  = s1.tag;
    end

    logic [GW-1:0] ext;
    logic [23:0]   m24;
    logic [24:0]   m25;
    logic [7:0]    exp_b;
    logic          g, s, inc, unused_hidden;

    // Zero padding below the operand makes G=S=0 for narrow widths.
    always_comb begin
        ext = {s2.norm, 24'b0};
        m24 = ext[GW-1 -: 24];
        g   = ext[W-1];
        s   = |ext[W-2:0];
        inc = 1'b0;
        unique case (s2.rm)
            RM_RNE: inc = g & (s | m24[0]);
            RM_RTZ: inc = 1'b0;
            RM_RDN: inc = (g | s) & s2.sign;
            RM_RUP: inc = (g | s) & !s2.sign;
        endcase
        m25   = {1'b0, m24} + 25'(inc);
        exp_b = s2.e + 8'(FP32_BIAS) + 8'(m25[24]);
        unused_hidden = m25[23];
        s3_d  = '0;
        s3_d.tag = s2.tag;
        if (!s2.zero) begin
            s3_d.f = fp32_pack(s2.sign, exp_b,
                               m25[24] ? 23'd0 : m25[22:0]);
            s3_d.inexact = g | s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else if (adv) begin
            v1 <= in_valid;
            v2 <= v1;
            v3 <= v2;
            s1 <= s1_d;
            s2 <= s2_d;
            s3 <= s3_d;
        end
    end

    assign out_valid   = v3;
    assign out_float   = s3.f;
    assign out_inexact = s3.inexact;
    assign out_tag     = s3.tag;

endmodule
